// File: rtl/sw_pass_scheduler_pkg.sv
// Shared definitions for the Smith-Waterman PE array and its pass scheduler:
// score width, spill RAM geometry, base encoding, spill word layout and the
// scheduler state encoding.
package sw_pass_scheduler_pkg;

    localparam int unsigned VEF_BIT   = 16;
    localparam int unsigned T_MAX_LEN = 1024;
    localparam int unsigned ADDR_W    = 10;

    // 2-bit nucleotide encoding used on every t bus
    typedef enum logic [1:0] {
        BASE_A = 2'd0,
        BASE_C = 2'd1,
        BASE_G = 2'd2,
        BASE_T = 2'd3
    } base_e;

    // One last-column element as stored between passes
    typedef struct packed {
        logic [1:0]         t;
        logic [VEF_BIT-1:0] v;
        logic [VEF_BIT-1:0] f;
    } spill_word_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FEED  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_e;

    // Width of a spill word {t, v, f} for a given score width
    function automatic int unsigned spill_width(input int unsigned vef);
        return 2 + 2 * vef;
    endfunction

endpackage

// File: rtl/sw_spill_ram.sv
// Simple dual-port spill RAM: one write port, one synchronous read port with
// one cycle of read latency. Contents are not reset.
// Ports: clk; i_we/i_waddr/i_wdata write port; i_re/i_raddr read request;
// o_rdata read data, valid the cycle after i_re.
module sw_spill_ram #(
    parameter int unsigned DEPTH = sw_pass_scheduler_pkg::T_MAX_LEN,
    parameter int unsigned AW    = sw_pass_scheduler_pkg::ADDR_W,
    parameter int unsigned DW    = sw_pass_scheduler_pkg::spill_width(sw_pass_scheduler_pkg::VEF_BIT)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    import sw_pass_scheduler_pkg::*;

    logic [DW-1:0] r_mem [DEPTH];

    // write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // registered read port
    always_ff @(posedge clk) begin
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/sw_pass_scheduler.sv
// Multi-pass sequencer for the Smith-Waterman PE array. Pass 0 streams the
// target from the source with zero boundary scores; every pass captures the
// array's last-column output into the spill RAM, and later passes replay it.
// Ports: i_start/i_t_len/i_pass_num job control; o_busy/o_done/o_err status;
// i_src_* / o_src_ready target source (pass 0 only); o_arr_* / i_arr_ready
// array input stream; o_pass_first/o_pass_idx pass tags; i_ret_* array
// last-column return (no backpressure).
module sw_pass_scheduler #(
    parameter int unsigned VEF_BIT   = sw_pass_scheduler_pkg::VEF_BIT,
    parameter int unsigned T_MAX_LEN = sw_pass_scheduler_pkg::T_MAX_LEN,
    parameter int unsigned ADDR_W    = sw_pass_scheduler_pkg::ADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [ADDR_W:0]    i_t_len,
    input  logic [7:0]         i_pass_num,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err,
    input  logic               i_src_valid,
    output logic               o_src_ready,
    input  logic [1:0]         i_src_t,
    output logic               o_arr_valid,
    input  logic               i_arr_ready,
    output logic [1:0]         o_arr_t,
    output logic [VEF_BIT-1:0] o_arr_v,
    output logic [VEF_BIT-1:0] o_arr_f,
    output logic               o_arr_last,
    output logic               o_pass_first,
    output logic [7:0]         o_pass_idx,
    input  logic               i_ret_valid,
    input  logic [1:0]         i_ret_t,
    input  logic [VEF_BIT-1:0] i_ret_v,
    input  logic [VEF_BIT-1:0] i_ret_f
);
    import sw_pass_scheduler_pkg::*;

    localparam int unsigned CNT_W   = ADDR_W + 1;
    localparam int unsigned SPILL_W = spill_width(VEF_BIT);

    typedef struct packed {
        logic               last;
        logic [1:0]         t;
        logic [VEF_BIT-1:0] v;
        logic [VEF_BIT-1:0] f;
    } out_ent_t;

    sched_state_e       r_state;
    sched_state_e       w_state_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [CNT_W-1:0]   r_t_len;
    logic [7:0]         r_pass_num;
    logic [7:0]         r_pass_idx;
    logic               r_pass_first;
    logic [CNT_W-1:0]   r_sent;
    logic [CNT_W-1:0]   r_rd;
    logic [CNT_W-1:0]   r_wr;
    logic [1:0]         r_cnt;
    out_ent_t           r_buf0;
    out_ent_t           r_buf1;
    logic               r_rd_pend;
    logic               r_rd_last;

    logic               w_start_ok;
    logic               w_job_bad;
    logic               w_len_bad;
    logic               w_pass_start;
    logic [8:0]         w_pass_inc;
    logic [CNT_W-1:0]   w_t_last;
    logic               w_pop;
    logic               w_src_ready;
    logic               w_src_fire;
    logic [1:0]         w_occ;
    logic               w_room;
    logic               w_rd_en;
    logic               w_push;
    out_ent_t           w_push_ent;
    logic               w_ret_bad;
    logic               w_wr_en;
    logic [CNT_W-1:0]   w_wr_nxt;
    logic [SPILL_W-1:0] w_ram_q;

    // job qualification and per-cycle handshakes
    always_comb begin
        w_start_ok   = i_start && (r_state == ST_IDLE);
        w_len_bad    = i_t_len > CNT_W'(T_MAX_LEN);
        w_job_bad    = (i_t_len == '0) || (i_pass_num == 8'd0) || w_len_bad;
        w_pass_inc   = {1'b0, r_pass_idx} + 9'd1;
        w_t_last     = r_t_len - CNT_W'(1);
        w_pop        = (r_cnt != 2'd0) && i_arr_ready;
        w_src_ready  = (r_state == ST_FEED) && r_pass_first && (r_cnt != 2'd2) && (r_rd < r_t_len);
        w_src_fire   = w_src_ready && i_src_valid;
        // occupancy after this cycle's pop plus the read already in flight
        w_occ        = r_cnt - 2'(w_pop);
        w_room       = (3'(w_occ) + 3'(r_rd_pend)) < 3'd2;
        w_rd_en      = (r_state == ST_FEED) && !r_pass_first && (r_rd < r_t_len) && w_room;
        w_push       = w_src_fire || r_rd_pend;
        // a return with no matching send, or beyond the pass length, is dropped
        w_ret_bad    = i_ret_valid && ((r_wr == r_sent) || (r_wr == r_t_len));
        w_wr_en      = i_ret_valid && !w_ret_bad;
        w_wr_nxt     = r_wr + CNT_W'(w_wr_en);
    end

    // entry written into the output buffer: RAM replay or pass-0 source
    always_comb begin
        w_push_ent = '0;
        if (r_rd_pend) begin
            w_push_ent.last = r_rd_last;
            {w_push_ent.t, w_push_ent.v, w_push_ent.f} = w_ram_q;
        end else begin
            w_push_ent.last = (r_rd == w_t_last);
            w_push_ent.t    = i_src_t;
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // next-state and registered-status decode
    always_comb begin
        w_state_nxt = r_state;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_start_ok) w_state_nxt = w_job_bad ? ST_DONE : ST_FEED;
            ST_FEED:  if (r_sent == r_t_len) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_wr_nxt == r_t_len) w_state_nxt = ST_NEXT;
            ST_NEXT:  w_state_nxt = (w_pass_inc < {1'b0, r_pass_num}) ? ST_FEED : ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt == ST_FEED) || (w_state_nxt == ST_DRAIN) || (w_state_nxt == ST_NEXT);
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    assign w_pass_start = (w_state_nxt == ST_FEED) && (r_state != ST_FEED);

    // job registers, pass counters and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err        <= 1'b0;
            r_t_len      <= '0;
            r_pass_num   <= 8'd0;
            r_pass_idx   <= 8'd0;
            r_pass_first <= 1'b0;
            r_sent       <= '0;
            r_rd         <= '0;
            r_wr         <= '0;
            r_rd_pend    <= 1'b0;
            r_rd_last    <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_t_len    <= i_t_len;
                r_pass_num <= i_pass_num;
                r_err      <= w_len_bad;
            end
            if (w_ret_bad) begin
                r_err <= 1'b1;
            end
            if (w_pass_start) begin
                r_sent <= '0;
                r_rd   <= '0;
                r_wr   <= '0;
                if (r_state == ST_IDLE) begin
                    r_pass_idx   <= 8'd0;
                    r_pass_first <= 1'b1;
                end else begin
                    r_pass_idx   <= w_pass_inc[7:0];
                    r_pass_first <= 1'b0;
                end
            end else begin
                r_sent <= r_sent + CNT_W'(w_pop);
                r_rd   <= r_rd + CNT_W'(w_src_fire || w_rd_en);
                r_wr   <= w_wr_nxt;
            end
            if (w_state_nxt == ST_DONE) begin
                r_pass_first <= 1'b0;
            end
            r_rd_pend <= w_rd_en;
            r_rd_last <= w_rd_en && (r_rd == w_t_last);
        end
    end

    // 2-entry output buffer; head entry drives the array port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= 2'd0;
            r_buf0 <= '0;
            r_buf1 <= '0;
        end else begin
            if (w_pop) begin
                if (r_cnt == 2'd2) begin
                    r_buf0 <= r_buf1;
                    if (w_push) r_buf1 <= w_push_ent;
                end else if (w_push) begin
                    r_buf0 <= w_push_ent;
                end
            end else if (w_push) begin
                if (r_cnt == 2'd0) r_buf0 <= w_push_ent;
                else               r_buf1 <= w_push_ent;
            end
            r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
        end
    end

    sw_spill_ram #(
        .DEPTH (T_MAX_LEN),
        .AW    (ADDR_W),
        .DW    (SPILL_W)
    ) u_spill_ram (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (r_wr[ADDR_W-1:0]),
        .i_wdata ({i_ret_t, i_ret_v, i_ret_f}),
        .i_re    (w_rd_en),
        .i_raddr (r_rd[ADDR_W-1:0]),
        .o_rdata (w_ram_q)
    );

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_src_ready  = w_src_ready;
    assign o_arr_valid  = (r_cnt != 2'd0);
    assign o_arr_t      = r_buf0.t;
    assign o_arr_v      = r_buf0.v;
    assign o_arr_f      = r_buf0.f;
    assign o_arr_last   = r_buf0.last;
    assign o_pass_first = r_pass_first;
    assign o_pass_idx   = r_pass_idx;

endmodule
